// File: rtl/smbus_relay_filter_pkg.sv
`default_nettype none
// ============================================================================
// smbus_relay_filter_pkg : shared CTRL bits, CSR offsets, counter width, FSM enum
// Rev 1.0
// ============================================================================
package smbus_relay_filter_pkg;

  localparam int CNT_W              = 16;

  localparam int CTRL_LOCK_BIT      = 0;
  localparam int CTRL_RELOAD_BIT    = 1;
  localparam int CTRL_CLR_CNT_BIT   = 2;
  localparam int CTRL_INIT_DONE_BIT = 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // relay is 1-based, k selects the 32-bit slice of the 128-bit bitmap
  function automatic int bitmap_word_addr(input int relay, input int k);
    return 4 * (relay - 1) + k;
  endfunction

  function automatic int ctrl_addr(input int num_relays);
    return 4 * num_relays;
  endfunction

  function automatic int cnt_addr(input int num_relays, input int relay);
    return 4 * num_relays + relay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/smbus_relay_filter_counter.sv
`default_nettype none
// ============================================================================
// smbus_relay_filter_counter : saturating event counter, clear has priority
// Rev 1.0
// ============================================================================
module smbus_relay_filter_counter
  import smbus_relay_filter_pkg::*;
(
  input  logic             clk,
  input  logic             i_resetn,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/smbus_relay_addr_filter.sv
`default_nettype none
// ============================================================================
// smbus_relay_addr_filter : per-relay 7-bit address whitelist with Avalon-MM CSR
// Rev 1.0
// ============================================================================
module smbus_relay_addr_filter
  import smbus_relay_filter_pkg::*;
#(
  parameter int                                     NUM_RELAYS     = 3,
  parameter int                                     MAX_ADDRESSES  = 17,
  parameter logic [NUM_RELAYS:1][7:0]               DEFAULT_COUNTS = '0,
  parameter logic [NUM_RELAYS:1][MAX_ADDRESSES:1][6:0] DEFAULT_ADDRS = '0,
  parameter int                                     AVMM_ADDR_W    = 8
) (
  input  logic                    clk,
  input  logic                    i_resetn,
  input  logic [NUM_RELAYS-1:0]   i_lkp_valid,
  input  logic [NUM_RELAYS*7-1:0] i_lkp_addr,
  output logic                    o_lkp_ready,
  output logic [NUM_RELAYS-1:0]   o_lkp_resp_valid,
  output logic [NUM_RELAYS-1:0]   o_lkp_allow,
  output logic                    o_init_done,
  input  logic [AVMM_ADDR_W-1:0]  i_avmm_address,
  input  logic                    i_avmm_read,
  input  logic                    i_avmm_write,
  input  logic [31:0]             i_avmm_writedata,
  output logic [31:0]             o_avmm_readdata
);

  localparam int RW = $clog2(NUM_RELAYS + 1);
  localparam int EW = $clog2(MAX_ADDRESSES + 1);

  fsm_t                        state_q, state_d;
  logic [RW-1:0]               relay_q, relay_d;
  logic [EW-1:0]               entry_q, entry_d;
  logic [NUM_RELAYS:1][127:0]  bitmap_q, bitmap_d;
  logic                        lock_q, lock_d;
  logic [NUM_RELAYS-1:0]       resp_valid_q, resp_valid_d;
  logic [NUM_RELAYS-1:0]       allow_q, allow_d;
  logic [31:0]                 rdata_q, rdata_d;

  logic                        run;
  int                          addr_int;
  logic                        is_bitmap, is_ctrl, is_cnt;
  logic [RW-1:0]               word_relay, cnt_relay;
  logic [1:0]                  word_sel;
  logic                        bm_wr, ctrl_wr, reload, clr_cnt;
  logic [NUM_RELAYS-1:0]       lkp_accept, lkp_hit;
  logic [CNT_W-1:0]            hit_cnt [1:NUM_RELAYS];
  logic [CNT_W-1:0]            blk_cnt [1:NUM_RELAYS];

  assign run        = (state_q == RUN);
  assign addr_int   = int'(i_avmm_address);
  assign is_bitmap  = addr_int <= bitmap_word_addr(NUM_RELAYS, 3);
  assign is_ctrl    = addr_int == ctrl_addr(NUM_RELAYS);
  assign is_cnt     = (addr_int > ctrl_addr(NUM_RELAYS)) &&
                      (addr_int <= cnt_addr(NUM_RELAYS, NUM_RELAYS));
  assign word_relay = RW'(addr_int / 4 + 1);
  assign word_sel   = i_avmm_address[1:0];
  assign cnt_relay  = RW'(addr_int - ctrl_addr(NUM_RELAYS));

  // Bitmap and reload writes are locked out during INIT and once LOCK is set
  assign bm_wr   = i_avmm_write && is_bitmap && run && !lock_q;
  assign ctrl_wr = i_avmm_write && is_ctrl;
  assign reload  = ctrl_wr && i_avmm_writedata[CTRL_RELOAD_BIT] && run && !lock_q;
  assign clr_cnt = ctrl_wr && i_avmm_writedata[CTRL_CLR_CNT_BIT];
  assign lock_d  = lock_q | (ctrl_wr & i_avmm_writedata[CTRL_LOCK_BIT]);

  always_comb begin
    state_d  = state_q;
    relay_d  = relay_q;
    entry_d  = entry_q;
    bitmap_d = bitmap_q;
    case (state_q)
      INIT: begin
        if (int'(entry_q) <= int'(DEFAULT_COUNTS[relay_q])) begin
          bitmap_d[relay_q][DEFAULT_ADDRS[relay_q][entry_q]] = 1'b1;
        end
        if (entry_q == EW'(MAX_ADDRESSES)) begin
          entry_d = EW'(1);
          if (relay_q == RW'(NUM_RELAYS)) begin
            state_d = RUN;
            relay_d = RW'(1);
          end else begin
            relay_d = relay_q + RW'(1);
          end
        end else begin
          entry_d = entry_q + EW'(1);
        end
      end
      RUN: begin
        if (reload) begin
          bitmap_d = '0;
          state_d  = INIT;
          relay_d  = RW'(1);
          entry_d  = EW'(1);
        end else if (bm_wr) begin
          bitmap_d[word_relay][{word_sel, 5'd0} +: 32] = i_avmm_writedata;
        end
      end
      default: state_d = INIT;
    endcase
  end

  for (genvar r = 1; r <= NUM_RELAYS; r++) begin : g_relay
    logic [6:0] addr;
    assign addr            = i_lkp_addr[7*(r-1) +: 7];
    assign lkp_accept[r-1] = i_lkp_valid[r-1] && run;
    assign lkp_hit[r-1]    = bitmap_q[r][addr];

    smbus_relay_filter_counter u_hit_cnt (
      .clk      (clk),
      .i_resetn (i_resetn),
      .i_inc    (lkp_accept[r-1] && lkp_hit[r-1]),
      .i_clr    (clr_cnt),
      .o_count  (hit_cnt[r])
    );

    smbus_relay_filter_counter u_blk_cnt (
      .clk      (clk),
      .i_resetn (i_resetn),
      .i_inc    (lkp_accept[r-1] && !lkp_hit[r-1]),
      .i_clr    (clr_cnt),
      .o_count  (blk_cnt[r])
    );
  end

  always_comb begin
    resp_valid_d = lkp_accept;
    allow_d      = lkp_accept & lkp_hit;
  end

  // Read data reflects register contents before any same-cycle update
  always_comb begin
    rdata_d = '0;
    if (i_avmm_read) begin
      if (is_bitmap) begin
        rdata_d = bitmap_q[word_relay][{word_sel, 5'd0} +: 32];
      end else if (is_ctrl) begin
        rdata_d[CTRL_LOCK_BIT]      = lock_q;
        rdata_d[CTRL_INIT_DONE_BIT] = run;
      end else if (is_cnt) begin
        rdata_d = {blk_cnt[cnt_relay], hit_cnt[cnt_relay]};
      end
    end
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q      <= INIT;
      relay_q      <= RW'(1);
      entry_q      <= EW'(1);
      bitmap_q     <= '0;
      lock_q       <= 1'b0;
      resp_valid_q <= '0;
      allow_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      relay_q      <= relay_d;
      entry_q      <= entry_d;
      bitmap_q     <= bitmap_d;
      lock_q       <= lock_d;
      resp_valid_q <= resp_valid_d;
      allow_q      <= allow_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_lkp_ready      = run;
  assign o_init_done      = run;
  assign o_lkp_resp_valid = resp_valid_q;
  assign o_lkp_allow      = allow_q;
  assign o_avmm_readdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_smbus_relay_addr_filter.sv
`default_nettype none
// ============================================================================
// tb_smbus_relay_addr_filter : vector table, directed corners and random lookups
// Rev 1.0
// ============================================================================
module tb_smbus_relay_addr_filter;

  localparam logic [118:0] R3_ADDRS = {7'h09, 7'h0b, 7'h0a, 7'h26, 7'h24, 7'h22, 7'h20,
                                       7'h45, 7'h44, 7'h43, 7'h42, 7'h41, 7'h40,
                                       7'h4f, 7'h4e, 7'h4d, 7'h4c};
  localparam logic [118:0] R1_ADDRS = {77'b0, 7'h58, 7'h50, 7'h59, 7'h51, 7'h56, 7'h48};
  localparam logic [3:1][17:1][6:0] DEF_ADDRS  = {R3_ADDRS, 119'b0, R1_ADDRS};
  localparam logic [3:1][7:0]       DEF_COUNTS = {8'd17, 8'd0, 8'd6};

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  lkp_valid;
  logic [20:0] lkp_addr;
  logic        lkp_ready;
  logic [2:0]  resp_valid;
  logic [2:0]  allow;
  logic        init_done;
  logic [7:0]  avmm_address;
  logic        avmm_read, avmm_write;
  logic [31:0] avmm_writedata, avmm_readdata;

  always #5 clk = ~clk;

  smbus_relay_addr_filter #(
    .NUM_RELAYS     (3),
    .MAX_ADDRESSES  (17),
    .DEFAULT_COUNTS (DEF_COUNTS),
    .DEFAULT_ADDRS  (DEF_ADDRS),
    .AVMM_ADDR_W    (8)
  ) dut (
    .clk              (clk),
    .i_resetn         (resetn),
    .i_lkp_valid      (lkp_valid),
    .i_lkp_addr       (lkp_addr),
    .o_lkp_ready      (lkp_ready),
    .o_lkp_resp_valid (resp_valid),
    .o_lkp_allow      (allow),
    .o_init_done      (init_done),
    .i_avmm_address   (avmm_address),
    .i_avmm_read      (avmm_read),
    .i_avmm_write     (avmm_write),
    .i_avmm_writedata (avmm_writedata),
    .o_avmm_readdata  (avmm_readdata)
  );

  // Reference model: permit sets as plain bit arrays, counters as integers
  byte unsigned r1_list [6]  = '{8'h48, 8'h56, 8'h51, 8'h59, 8'h50, 8'h58};
  byte unsigned r3_list [17] = '{8'h4c, 8'h4d, 8'h4e, 8'h4f, 8'h40, 8'h41, 8'h42, 8'h43,
                                 8'h44, 8'h45, 8'h20, 8'h22, 8'h24, 8'h26, 8'h0a, 8'h0b, 8'h09};
  bit mbm  [3][128];
  int mhit [3];
  int mblk [3];
  bit mlock;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         relay;
    logic [6:0] addr;
    logic       allow;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_defaults();
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 128; a++) mbm[r][a] = 1'b0;
    foreach (r1_list[i]) mbm[0][r1_list[i]] = 1'b1;
    foreach (r3_list[i]) mbm[2][r3_list[i]] = 1'b1;
  endfunction

  function automatic void model_count(input int r, input bit hit);
    if (hit) mhit[r] = (mhit[r] < 65535) ? mhit[r] + 1 : 65535;
    else     mblk[r] = (mblk[r] < 65535) ? mblk[r] + 1 : 65535;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 3; r++) begin
      mhit[r] = 0;
      mblk[r] = 0;
    end
  endfunction

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[b] = mbm[w / 4][32 * (w % 4) + b];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    if (w < 12)  return model_word(w);
    if (w == 12) return 32'h100 | 32'(mlock);
    if (w <= 15) return 32'((mblk[w - 13] << 16) | mhit[w - 13]);
    return 32'h0;
  endfunction

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    avmm_address   = a;
    avmm_writedata = d;
    avmm_write     = 1'b1;
    tick();
    avmm_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    avmm_address = a;
    avmm_read    = 1'b1;
    tick();
    avmm_read    = 1'b0;
    d            = avmm_readdata;
  endtask

  task automatic lookup(input int r, input logic [6:0] a, output logic v, output logic al);
    lkp_valid         = 3'(1 << r);
    lkp_addr[7*r +: 7] = a;
    tick();
    lkp_valid         = 3'b0;
    v                 = resp_valid[r];
    al                = allow[r];
  endtask

  task automatic wait_init(input string name, input bit drive_lookups);
    int  done_at;
    bit  any_resp;
    done_at  = -1;
    any_resp = 1'b0;
    if (drive_lookups) begin
      lkp_valid = 3'b111;
      lkp_addr  = {7'h09, 7'h00, 7'h48};
    end
    for (int k = 1; k <= 80 && done_at < 0; k++) begin
      tick();
      if (resp_valid != 3'b0) any_resp = 1'b1;
      if (init_done) done_at = k;
    end
    lkp_valid = 3'b0;
    check(name, done_at, 51);
    check({name, "_ready"}, lkp_ready, 1'b1);
    if (drive_lookups) check("init_lookup_dropped", any_resp, 1'b0);
  endtask

  logic [31:0] rd, exp_rd, wd;
  logic        v, al;
  logic [2:0]  rv, exp_allow;
  logic [6:0]  ra [3];
  int          op, wa, lows;

  initial begin
    tbl[0] = '{0, 7'h48, 1'b1};
    tbl[1] = '{0, 7'h49, 1'b0};
    tbl[2] = '{0, 7'h58, 1'b1};
    tbl[3] = '{2, 7'h09, 1'b1};
    tbl[4] = '{2, 7'h4c, 1'b1};
    tbl[5] = '{1, 7'h48, 1'b0};
    tbl[6] = '{2, 7'h48, 1'b0};
    tbl[7] = '{0, 7'h00, 1'b0};

    resetn = 1'b0; lkp_valid = '0; lkp_addr = '0;
    avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0; avmm_writedata = '0;
    model_defaults(); model_clear(); mlock = 1'b0;

    repeat (3) tick();
    check("reset_outputs", {avmm_readdata, resp_valid, allow, lkp_ready, init_done}, 32'h0);
    check("reset_readdata", avmm_readdata, 32'h0);
    resetn = 1'b1;
    wait_init("init_done_cycle", 1'b1);

    foreach (tbl[i]) begin
      lookup(tbl[i].relay, tbl[i].addr, v, al);
      check("tbl_resp_valid", v, 1'b1);
      check("tbl_allow", al, tbl[i].allow);
      model_count(tbl[i].relay, tbl[i].allow);
    end
    csr_read(8'd2, rd);
    check("word2_default", rd, model_word(2));
    csr_read(8'd12, rd);
    check("ctrl_after_init", rd, 32'h100);

    // Same-cycle write and lookup sees the old bitmap; next cycle sees the new
    avmm_address = 8'd4; avmm_writedata = 32'h2; avmm_write = 1'b1;
    lkp_valid = 3'b010; lkp_addr[13:7] = 7'h01;
    tick();
    avmm_write = 1'b0; lkp_valid = 3'b0;
    check("same_cycle_wr_allow", {resp_valid[1], allow[1]}, 2'b10);
    model_count(1, 1'b0);
    mbm[1][1] = 1'b1;
    lookup(1, 7'h01, v, al);
    check("after_wr_allow", {v, al}, 2'b11);
    model_count(1, 1'b1);

    for (int c = 0; c < 400; c++) begin
      rv = 3'($urandom);
      op = $urandom_range(0, 9);
      for (int i = 0; i < 3; i++) begin
        ra[i] = 7'($urandom);
        lkp_addr[7*i +: 7] = ra[i];
        exp_allow[i] = rv[i] & mbm[i][ra[i]];
      end
      lkp_valid = rv;
      wa = 0; wd = '0; exp_rd = '0;
      if (op < 2) begin
        wa = $urandom_range(0, 11);
        wd = $urandom;
        avmm_address = 8'(wa); avmm_writedata = wd; avmm_write = 1'b1;
      end else if (op < 5) begin
        wa = $urandom_range(0, 17);
        exp_rd = model_read(wa);
        avmm_address = 8'(wa); avmm_read = 1'b1;
      end
      tick();
      avmm_write = 1'b0; avmm_read = 1'b0; lkp_valid = 3'b0;
      check("rand_resp_valid", resp_valid, rv);
      check("rand_allow", allow & rv, exp_allow);
      if (op >= 2 && op < 5) check("rand_readdata", avmm_readdata, exp_rd);
      for (int i = 0; i < 3; i++)
        if (rv[i]) model_count(i, exp_allow[i]);
      if (op < 2)
        for (int b = 0; b < 32; b++) mbm[wa / 4][32 * (wa % 4) + b] = wd[b];
    end
    for (int r = 0; r < 3; r++) begin
      csr_read(8'(13 + r), rd);
      check("counter_words", rd, model_read(13 + r));
    end

    // RELOAD restores defaults; a lookup in the write cycle still answers
    csr_write(8'd0, 32'hFFFF_FFFF);
    avmm_address = 8'd12; avmm_writedata = 32'h2; avmm_write = 1'b1;
    lkp_valid = 3'b001; lkp_addr[6:0] = 7'h00;
    tick();
    avmm_write = 1'b0; lkp_valid = 3'b0;
    check("reload_cycle_lookup", {resp_valid[0], allow[0]}, 2'b11);
    check("reload_init_done_drop", init_done, 1'b0);
    model_count(0, 1'b1);
    model_defaults();
    lows = 0;
    if (!lkp_ready) lows++;
    for (int j = 0; j < 100 && !lkp_ready; j++) begin
      tick();
      if (!lkp_ready) lows++;
    end
    check("reload_ready_low_cycles", lows, 51);
    lookup(0, 7'h48, v, al);
    check("reload_0x48", {v, al}, 2'b11);
    model_count(0, 1'b1);
    lookup(0, 7'h00, v, al);
    check("reload_0x00_gone", {v, al}, 2'b10);
    model_count(0, 1'b0);
    csr_read(8'd0, rd);
    check("reload_word0", rd, 32'h0);
    csr_read(8'd4, rd);
    check("reload_word4", rd, model_word(4));

    // Counter saturation and clear-wins
    csr_write(8'd12, 32'h4);
    model_clear();
    lkp_valid = 3'b010; lkp_addr[13:7] = 7'h10;
    for (int n = 0; n < 32'h10005; n++) begin
      tick();
      model_count(1, mbm[1][7'h10]);
    end
    lkp_valid = 3'b0;
    csr_read(8'd14, rd);
    check("blk_saturated", rd, 32'hFFFF_0000);
    check("blk_saturated_model", rd, model_read(14));
    avmm_address = 8'd12; avmm_writedata = 32'h4; avmm_write = 1'b1;
    lkp_valid = 3'b010;
    tick();
    avmm_write = 1'b0; lkp_valid = 3'b0;
    model_clear();
    csr_read(8'd14, rd);
    check("clr_wins", rd, 32'h0);

    // LOCK: bitmap writes and RELOAD ignored, clearing LOCK has no effect
    csr_write(8'd12, 32'h1);
    mlock = 1'b1;
    csr_write(8'd0, 32'h0);
    csr_write(8'd2, 32'h0);
    lookup(0, 7'h48, v, al);
    check("locked_0x48", {v, al}, 2'b11);
    csr_write(8'd12, 32'h2);
    check("locked_reload_ignored", {lkp_ready, init_done}, 2'b11);
    csr_read(8'd12, rd);
    check("ctrl_locked", rd, 32'h101);
    csr_write(8'd12, 32'h0);
    csr_read(8'd12, rd);
    check("lock_sticky", rd, model_read(12));
    csr_read(8'd16, rd);
    check("oor_read_16", rd, 32'h0);
    csr_read(8'hFF, rd);
    check("oor_read_ff", rd, 32'h0);

    // Reset in the middle of INIT restarts the walk
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (20) tick();
    resetn = 1'b0;
    #1;
    check("midinit_reset_outputs", {avmm_readdata, resp_valid, allow, lkp_ready, init_done}, 32'h0);
    repeat (2) tick();
    resetn = 1'b1;
    mlock = 1'b0; model_clear();
    wait_init("midinit_init_done_cycle", 1'b0);
    csr_read(8'd12, rd);
    check("ctrl_after_reset", rd, 32'h100);
    csr_read(8'd13, rd);
    check("cnt_after_reset", rd, 32'h0);
    lookup(0, 7'h48, v, al);
    check("post_reset_0x48", {v, al}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
